// File: rtl/mc_recon.sv
// Motion-compensation reconstruction: recon = pred + residual, one row per cycle,
// result held until the consumer accepts it. Pixel (r,c) sits at flat index r*MB_SIZE+c.
module mc_recon #(
  parameter int MB_SIZE     = 4,
  parameter int PIXEL_WIDTH = 8,
  parameter int RES_WIDTH   = 9,
  parameter int WRAP_MODE   = 0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [MB_SIZE*MB_SIZE*PIXEL_WIDTH-1:0]   pred_mb,
  input  logic [MB_SIZE*MB_SIZE*RES_WIDTH-1:0]     residual,
  input  logic                                     src_valid,
  output logic                                     src_ready,
  input  logic                                     dst_ready,
  output logic                                     dst_valid,
  output logic [MB_SIZE*MB_SIZE*PIXEL_WIDTH-1:0]   recon_mb
);

  localparam int SUM_W = ((RES_WIDTH > PIXEL_WIDTH + 1) ? RES_WIDTH : PIXEL_WIDTH + 1) + 1;
  localparam int CNT_W = (MB_SIZE > 1) ? $clog2(MB_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MB_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  logic [CNT_W-1:0]       row_cnt_r;
  logic                   dst_valid_r;
  logic [PIXEL_WIDTH-1:0] pred_r    [MB_SIZE][MB_SIZE];
  logic [RES_WIDTH-1:0]   res_r     [MB_SIZE][MB_SIZE];
  logic [PIXEL_WIDTH-1:0] recon_r   [MB_SIZE][MB_SIZE];
  logic [PIXEL_WIDTH-1:0] pred_in_s [MB_SIZE][MB_SIZE];
  logic [RES_WIDTH-1:0]   res_in_s  [MB_SIZE][MB_SIZE];
  logic [PIXEL_WIDTH-1:0] row_s     [MB_SIZE];

  // Saturating signed add, or modulo add of the low residual bits when wrapping.
  function automatic logic [PIXEL_WIDTH-1:0] recon_pixel(
    input logic [PIXEL_WIDTH-1:0] p,
    input logic [RES_WIDTH-1:0]   r
  );
    logic signed [SUM_W-1:0] sum_v;
    logic [PIXEL_WIDTH-1:0]  pix_v;
    sum_v = $signed({{(SUM_W-PIXEL_WIDTH){1'b0}}, p})
          + $signed({{(SUM_W-RES_WIDTH){r[RES_WIDTH-1]}}, r});
    if (WRAP_MODE != 0) begin
      pix_v = p + r[PIXEL_WIDTH-1:0];
    end else if (sum_v[SUM_W-1]) begin
      pix_v = {PIXEL_WIDTH{1'b0}};
    end else if (|sum_v[SUM_W-2:PIXEL_WIDTH]) begin
      pix_v = {PIXEL_WIDTH{1'b1}};
    end else begin
      pix_v = sum_v[PIXEL_WIDTH-1:0];
    end
    return pix_v;
  endfunction

  for (genvar gr = 0; gr < MB_SIZE; gr++) begin : g_row
    for (genvar gc = 0; gc < MB_SIZE; gc++) begin : g_col
      assign pred_in_s[gr][gc] = pred_mb[(gr*MB_SIZE+gc)*PIXEL_WIDTH +: PIXEL_WIDTH];
      assign res_in_s[gr][gc]  = residual[(gr*MB_SIZE+gc)*RES_WIDTH +: RES_WIDTH];
      assign recon_mb[(gr*MB_SIZE+gc)*PIXEL_WIDTH +: PIXEL_WIDTH] = recon_r[gr][gc];
    end
  end

  for (genvar gc = 0; gc < MB_SIZE; gc++) begin : g_calc
    assign row_s[gc] = recon_pixel(pred_r[row_cnt_r][gc], res_r[row_cnt_r][gc]);
  end

  assign src_ready = (state_r == IDLE) && !reset;
  assign dst_valid = dst_valid_r;

  // Row-counter FSM: capture in IDLE, one row per edge in CALC, hold in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      row_cnt_r   <= {CNT_W{1'b0}};
      dst_valid_r <= 1'b0;
      pred_r      <= '{default: '0};
      res_r       <= '{default: '0};
      recon_r     <= '{default: '0};
    end else begin
      case (state_r)
        IDLE: begin
          if (src_valid) begin
            pred_r    <= pred_in_s;
            res_r     <= res_in_s;
            row_cnt_r <= {CNT_W{1'b0}};
            state_r   <= CALC;
          end else begin
            state_r   <= IDLE;
          end
        end
        CALC: begin
          recon_r[row_cnt_r] <= row_s;
          if (row_cnt_r == LAST_ROW) begin
            row_cnt_r   <= {CNT_W{1'b0}};
            state_r     <= DONE;
            dst_valid_r <= 1'b1;
          end else begin
            row_cnt_r   <= row_cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (dst_ready) begin
            dst_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            dst_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          row_cnt_r   <= {CNT_W{1'b0}};
          dst_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_recon.sv
// Self-checking bench for mc_recon: a saturating and a wrapping instance share stimulus.
module tb_mc_recon;

  localparam int MB   = 4;
  localparam int PW   = 8;
  localparam int RW   = 9;
  localparam int NPIX = MB * MB;

  logic              clk = 1'b0;
  logic              reset;
  logic [NPIX*PW-1:0] pred_mb;
  logic [NPIX*RW-1:0] residual;
  logic              src_valid;
  logic              dst_ready;
  logic              src_ready0, dst_valid0, src_ready1, dst_valid1;
  logic [NPIX*PW-1:0] recon0, recon1;

  int total = 0;
  int bad   = 0;
  int cur_p [NPIX];
  int cur_r [NPIX];

  typedef struct {
    int         p;
    int         r;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  mc_recon #(.MB_SIZE(MB), .PIXEL_WIDTH(PW), .RES_WIDTH(RW), .WRAP_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .pred_mb(pred_mb), .residual(residual),
    .src_valid(src_valid), .src_ready(src_ready0), .dst_ready(dst_ready),
    .dst_valid(dst_valid0), .recon_mb(recon0)
  );

  mc_recon #(.MB_SIZE(MB), .PIXEL_WIDTH(PW), .RES_WIDTH(RW), .WRAP_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .pred_mb(pred_mb), .residual(residual),
    .src_valid(src_valid), .src_ready(src_ready1), .dst_ready(dst_ready),
    .dst_valid(dst_valid1), .recon_mb(recon1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer add with clamp, or add modulo 256 of the low residual byte.
  function automatic logic [7:0] ref_pix(int p, int r, int wrap);
    int s;
    if (wrap != 0) s = (p + (r & 255)) % 256;
    else begin
      s = p + r;
      if (s < 0) s = 0;
      else if (s > 255) s = 255;
    end
    return 8'(s);
  endfunction

  function automatic logic [NPIX*PW-1:0] model_block(int wrap);
    logic [NPIX*PW-1:0] v;
    for (int i = 0; i < NPIX; i++) v[i*PW +: PW] = ref_pix(cur_p[i], cur_r[i], wrap);
    return v;
  endfunction

  function automatic logic [NPIX*PW-1:0] fill(logic [7:0] b);
    return {NPIX{b}};
  endfunction

  task automatic set_uniform(input int p, input int r);
    for (int i = 0; i < NPIX; i++) begin
      cur_p[i] = p;
      cur_r[i] = r;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NPIX; i++) begin
      pred_mb[i*PW +: PW]  = 8'(cur_p[i]);
      residual[i*RW +: RW] = 9'(cur_r[i]);
    end
  endtask

  // Present the current block, wait for acceptance, then count edges to dst_valid.
  task automatic send_block(input string nm);
    int n;
    apply();
    src_valid = 1'b1;
    n = 0;
    while (!src_ready0 && n < 50) begin tick(); n++; end
    chk({nm, " accept"}, src_ready0, 1'b1);
    tick();
    src_valid = 1'b0;
    n = 0;
    while (!dst_valid0 && n < 50) begin tick(); n++; end
    chk({nm, " latency"}, n, MB);
    chk({nm, " dv1"}, dst_valid1, 1'b1);
  endtask

  task automatic release_block(input string nm, input int hold);
    dst_ready = 1'b0;
    repeat (hold) tick();
    dst_ready = 1'b1;
    tick();
    dst_ready = 1'b0;
    chk({nm, " handshake"}, {dst_valid0, src_ready0}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NPIX*PW-1:0] snap;
    logic [NPIX*PW-1:0] expv;
    int curr [NPIX];
    int n, seen;

    vecs[0] = '{p: 100, r: 20,   e0: 8'd120, e1: 8'd120};
    vecs[1] = '{p: 250, r: 10,   e0: 8'd255, e1: 8'd4};
    vecs[2] = '{p: 5,   r: -9,   e0: 8'd0,   e1: 8'd252};
    vecs[3] = '{p: 0,   r: 255,  e0: 8'd255, e1: 8'd255};
    vecs[4] = '{p: 255, r: -256, e0: 8'd0,   e1: 8'd255};
    vecs[5] = '{p: 200, r: 100,  e0: 8'd255, e1: 8'd44};
    vecs[6] = '{p: 10,  r: -10,  e0: 8'd0,   e1: 8'd0};

    reset = 1'b1; src_valid = 1'b0; dst_ready = 1'b0;
    pred_mb = '0; residual = '0;
    repeat (3) tick();
    chk("reset state", {src_ready0, dst_valid0, src_ready1, dst_valid1, recon0, recon1}, '0);

    // Reset release with input and consumer both ready.
    set_uniform(100, 20);
    apply();
    src_valid = 1'b1;
    dst_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("t1 first ready", src_ready0, 1'b1);
    tick();
    src_valid = 1'b0;
    n = 0;
    while (!dst_valid0 && n < 50) begin tick(); n++; end
    chk("t1 latency", n, MB);
    chk("t1 recon0", recon0, fill(8'd120));
    chk("t1 recon1", recon1, fill(8'd120));
    tick();
    chk("t1 ready again", {dst_valid0, src_ready0}, 2'b01);
    dst_ready = 1'b0;

    // Uniform-block table covering saturation and modulo corners.
    for (int i = 0; i < 7; i++) begin
      set_uniform(vecs[i].p, vecs[i].r);
      send_block($sformatf("vec%0d", i));
      chk($sformatf("vec%0d recon0", i), recon0, fill(vecs[i].e0));
      chk($sformatf("vec%0d recon1", i), recon1, fill(vecs[i].e1));
      release_block($sformatf("vec%0d", i), i % 3);
    end

    // Random blocks against the reference model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < NPIX; i++) begin
        cur_p[i] = int'($urandom_range(0, 255));
        cur_r[i] = int'($urandom_range(0, 511)) - 256;
      end
      send_block($sformatf("rnd%0d", t));
      chk($sformatf("rnd%0d recon0", t), recon0, model_block(0));
      chk($sformatf("rnd%0d recon1", t), recon1, model_block(1));
      release_block($sformatf("rnd%0d", t), int'($urandom_range(0, 3)));
    end

    // Encoder round trip in wrap mode reproduces the current block.
    for (int i = 0; i < NPIX; i++) begin
      curr[i]  = int'($urandom_range(0, 255));
      cur_p[i] = int'($urandom_range(0, 255));
      cur_r[i] = (curr[i] - cur_p[i]) & 255;
      if (cur_r[i] > 127) cur_r[i] = cur_r[i] - 256;
      expv[i*PW +: PW] = 8'(curr[i]);
    end
    send_block("roundtrip");
    chk("roundtrip recon1", recon1, expv);
    release_block("roundtrip", 0);

    // Backpressure with a second block waiting on src_valid.
    set_uniform(30, 5);
    send_block("bp A");
    snap = recon0;
    chk("bp A value", snap, fill(8'd35));
    set_uniform(60, -7);
    apply();
    src_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("bp hold%0d", k), {dst_valid0, src_ready0, recon0}, {1'b1, 1'b0, snap});
    end
    dst_ready = 1'b1;
    tick();
    dst_ready = 1'b0;
    chk("bp after handshake", {dst_valid0, src_ready0}, 2'b01);
    tick();
    src_valid = 1'b0;
    chk("bp B taken", src_ready0, 1'b0);
    n = 0;
    while (!dst_valid0 && n < 50) begin tick(); n++; end
    chk("bp B latency", n, MB);
    chk("bp B recon0", recon0, fill(8'd53));
    chk("bp B recon1", recon1, fill(8'd53));
    release_block("bp B", 0);

    // Row ordering: rows appear one per edge over an all-zero previous block.
    set_uniform(0, 0);
    send_block("zero");
    release_block("zero", 0);
    for (int i = 0; i < NPIX; i++) begin
      cur_p[i] = 50;
      cur_r[i] = (i / MB) * 10;
    end
    apply();
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    chk("rows E0", recon0, '0);
    for (int k = 1; k <= MB; k++) begin
      tick();
      for (int i = 0; i < NPIX; i++)
        expv[i*PW +: PW] = ((i / MB) < k) ? 8'(50 + 10 * (i / MB)) : 8'd0;
      chk($sformatf("rows E%0d recon0", k), recon0, expv);
      chk($sformatf("rows E%0d recon1", k), recon1, expv);
    end
    chk("rows dv", dst_valid0, 1'b1);
    release_block("rows", 0);

    // Asynchronous reset in the middle of CALC discards the block.
    set_uniform(100, 20);
    apply();
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("midreset", {dst_valid0, src_ready0, dst_valid1, recon0, recon1}, '0);
    tick();
    tick();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (dst_valid0 || dst_valid1) seen++;
    end
    chk("no stale block", seen, 0);
    set_uniform(7, 3);
    send_block("post reset");
    chk("post reset recon0", recon0, fill(8'd10));
    chk("post reset recon1", recon1, fill(8'd10));
    release_block("post reset", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
